// File: rtl/bsg_mem_1rw_sync_mask_write_byte_frontend_fifo.sv
// ----------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_byte_frontend_fifo
//
// Circular buffer that holds read responses that could not be handed to the
// consumer in the cycle they came back from the RAM. Control state (pointers,
// occupancy count) resets asynchronously. The storage array is not reset
// because every entry is written before it can be observed.
//
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   enq_v_i         push enq_data_i at the tail this cycle
//   enq_data_i      data to push
//   deq_yumi_i      pop the head this cycle
//   head_data_o     oldest stored entry (don't-care when empty_o=1)
//   empty_o         no entries stored
//   full_o          all els_p entries in use
//   count_o         number of stored entries (used by the parent's credit check)
// ----------------------------------------------------------------------------
module bsg_mem_1rw_sync_mask_write_byte_frontend_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 2,
    parameter int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enq_v_i,
    input  logic [width_p-1:0]  enq_data_i,
    input  logic                deq_yumi_i,
    output logic [width_p-1:0]  head_data_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] head_q, head_d;
    logic [ptr_w_lp-1:0] tail_q, tail_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    // Pointers wrap modulo els_p, which need not be a power of two.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(els_p - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == cnt_w_lp'(els_p));
    assign count_o     = count_q;
    assign head_data_o = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_v_i) begin
            tail_d = ptr_inc(tail_q);
        end
        if (deq_yumi_i) begin
            head_d = ptr_inc(head_q);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({enq_v_i, deq_yumi_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_v_i) begin
            mem_q[tail_q] <= enq_data_i;
        end
    end

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(enq_v_i && full_o));
            assert (!(deq_yumi_i && empty_o));
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_frontend.sv
// ----------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_byte_frontend
//
// Ready/valid front end for a 1-port synchronous byte-masked RAM with
// 1-cycle read latency. Requests are passed straight through to the RAM port
// when accepted; read data returning the next cycle is either handed to the
// consumer directly (bypass) or parked in a small response FIFO. Requests are
// only accepted while there is guaranteed room for the resulting response, so
// read data is never dropped under backpressure.
//
// Ports:
//   clk_i, reset_i               clock, asynchronous active-high reset
//   v_i, w_i, addr_i, data_i,
//   mask_i, ready_o              request channel (ready_and handshake)
//   v_o, data_o, yumi_i          read response channel (valid/yumi)
//   ram_v_o, ram_w_o, ram_addr_o,
//   ram_data_o, ram_mask_o       RAM access port
//   ram_data_i                   RAM read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module bsg_mem_1rw_sync_mask_write_byte_frontend #(
    parameter int els_p         = 16,
    parameter int data_width_p  = 32,
    parameter int fifo_els_p    = 2,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int mask_width_lp = data_width_p >> 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] mask_i,
    output logic                     ready_o,

    output logic                     v_o,
    output logic [data_width_p-1:0]  data_o,
    input  logic                     yumi_i,

    output logic                     ram_v_o,
    output logic                     ram_w_o,
    output logic [addr_width_lp-1:0] ram_addr_o,
    output logic [data_width_p-1:0]  ram_data_o,
    output logic [mask_width_lp-1:0] ram_mask_o,
    input  logic [data_width_p-1:0]  ram_data_i
);

    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    logic                    rd_pend_q, rd_pend_d;
    logic                    accept;
    logic                    fifo_enq_v;
    logic                    fifo_deq;
    logic [data_width_p-1:0] fifo_head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [cnt_w_lp-1:0]     fifo_count;
    logic [cnt_w_lp:0]       occupancy;

    // Credit check: a read in flight already owns a FIFO slot, so count it.
    // Writes are gated as well so the request channel behaves uniformly.
    assign occupancy = {1'b0, fifo_count} + (cnt_w_lp + 1)'(rd_pend_q);
    assign ready_o   = ~reset_i & (occupancy < (cnt_w_lp + 1)'(fifo_els_p));
    assign accept    = v_i & ready_o;

    assign ram_v_o    = accept;
    assign ram_w_o    = w_i;
    assign ram_addr_o = addr_i;
    assign ram_data_o = data_i;
    assign ram_mask_o = mask_i;

    assign rd_pend_d = accept & ~w_i;

    // Response path: with an empty FIFO the returning read data is presented
    // directly; it is only stored if the consumer does not take it at once.
    // Otherwise the FIFO head is older and must go first.
    assign v_o        = rd_pend_q | ~fifo_empty;
    assign data_o     = fifo_empty ? ram_data_i : fifo_head;
    assign fifo_enq_v = rd_pend_q & ~(fifo_empty & yumi_i);
    assign fifo_deq   = yumi_i & ~fifo_empty;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    bsg_mem_1rw_sync_mask_write_byte_frontend_fifo #(
        .width_p (data_width_p),
        .els_p   (fifo_els_p)
    ) resp_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enq_v_i     (fifo_enq_v),
        .enq_data_i  (ram_data_i),
        .deq_yumi_i  (fifo_deq),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o));
            assert (!(fifo_enq_v && fifo_full && !fifo_deq));
        end
    end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_frontend.sv
module tb_bsg_mem_1rw_sync_mask_write_byte_frontend;

    localparam int ELS  = 16;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int MW   = 4;
    localparam int FELS = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i, w_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [MW-1:0] mask_i;
    logic          ready_o;
    logic          v_o;
    logic [DW-1:0] data_o;
    logic          yumi_i;
    logic          ram_v_o, ram_w_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic [MW-1:0] ram_mask_o;
    logic [DW-1:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference state: expected memory image and in-order outstanding responses.
    logic [DW-1:0] ref_mem [ELS];
    logic [DW-1:0] exp_q [$];

    bsg_mem_1rw_sync_mask_write_byte_frontend #(
        .els_p        (ELS),
        .data_width_p (DW),
        .fifo_els_p   (FELS)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .w_i        (w_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .mask_i     (mask_i),
        .ready_o    (ready_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .ram_v_o    (ram_v_o),
        .ram_w_o    (ram_w_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_mask_o (ram_mask_o),
        .ram_data_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // Attached RAM: 1-cycle read latency, no-change on write, byte masked.
    logic [DW-1:0] ram_mem [ELS];
    always @(posedge clk) begin
        if (ram_v_o) begin
            if (ram_w_o) begin
                for (int b = 0; b < MW; b++) begin
                    if (ram_mask_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
                end
            end else begin
                ram_rdata <= ram_mem[ram_addr_o];
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at the falling edge, update
    // the reference, then advance to the next posedge+1.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m, input logic y);
        logic          acc;
        logic [DW-1:0] bm;
        v_i = v; w_i = w; addr_i = a; data_i = d; mask_i = m;
        yumi_i = y && (exp_q.size() > 0);
        #4;
        acc = v && (exp_q.size() < FELS);
        chk1("ready_o", ready_o, exp_q.size() < FELS);
        chk1("v_o", v_o, exp_q.size() > 0);
        chk1("ram_v_o", ram_v_o, acc);
        if (acc) begin
            chk1("ram_w_o", ram_w_o, w);
            chk32("ram_addr_o", {{(DW-AW){1'b0}}, ram_addr_o}, {{(DW-AW){1'b0}}, a});
            if (w) begin
                chk32("ram_data_o", ram_data_o, d);
                chk32("ram_mask_o", {{(DW-MW){1'b0}}, ram_mask_o}, {{(DW-MW){1'b0}}, m});
            end
        end
        if (exp_q.size() > 0) chk32("data_o", data_o, exp_q[0]);
        if (yumi_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            if (w) begin
                bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
                ref_mem[a] = (ref_mem[a] & ~bm) | (d & bm);
            end else begin
                exp_q.push_back(ref_mem[a]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        v_i = 1'b1; w_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0; yumi_i = 1'b0;
        for (int i = 0; i < ELS; i++) ref_mem[i] = '0;

        // Reset state
        #2;
        chk1("rst_v_o", v_o, 1'b0);
        chk1("rst_ready_o", ready_o, 1'b0);
        chk1("rst_ram_v_o", ram_v_o, 1'b0);
        @(posedge clk);
        @(posedge clk);
        v_i = 1'b0;
        #3 reset_i = 1'b0;
        #1;
        chk1("post_rst_ready", ready_o, 1'b1);
        @(posedge clk);
        #1;

        // Define every RAM word through the DUT
        for (int i = 0; i < ELS; i++) step(1, 1, AW'(i), $urandom, 4'hF, 0);

        // Full write then read, 1-cycle latency
        step(1, 1, 3, 32'hDEADBEEF, 4'hF, 0);
        step(1, 0, 3, 0, 0, 0);
        chk1("wr_rd_v", v_o, 1'b1);
        chk32("wr_rd_data", data_o, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 1);

        // Byte merge, then a mask-0 write that must change nothing
        step(1, 1, 3, 32'h11223344, 4'b0101, 0);
        step(1, 0, 3, 0, 0, 0);
        chk32("merge_data", data_o, 32'hDE22BE44);
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 3, 32'hFFFFFFFF, 4'b0000, 0);
        chk1("mask0_no_resp", v_o, 1'b0);
        step(1, 0, 3, 0, 0, 0);
        chk32("mask0_data", data_o, 32'hDE22BE44);
        step(0, 0, 0, 0, 0, 1);

        // Backpressure: third read blocked, head held stable
        step(1, 1, 1, 32'h0000000A, 4'hF, 0);
        step(1, 1, 2, 32'h0000000B, 4'hF, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0);
        chk1("bp_ready_low", ready_o, 1'b0);
        chk32("bp_hold_a", data_o, 32'h0000000A);
        step(1, 0, 3, 0, 0, 0);
        chk32("bp_hold_a2", data_o, 32'h0000000A);
        step(1, 0, 3, 0, 0, 1);
        chk32("bp_head_b", data_o, 32'h0000000B);
        chk1("bp_ready_back", ready_o, 1'b1);
        step(1, 0, 3, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Streaming with yumi held high
        for (int i = 0; i < 8; i++) step(1, 0, AW'(i), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Asynchronous reset with one buffered and one pending response
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd5; yumi_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk1("arst_v_o", v_o, 1'b0);
        chk1("arst_ready_o", ready_o, 1'b0);
        chk1("arst_ram_v_o", ram_v_o, 1'b0);
        exp_q.delete();
        v_i = 1'b0;
        @(posedge clk);
        #3 reset_i = 1'b0;
        #1;
        chk1("arst_rel_ready", ready_o, 1'b1);
        chk1("arst_rel_v_o", v_o, 1'b0);
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0);
        chk32("arst_fresh_read", data_o, 32'hDE22BE44);
        step(0, 0, 0, 0, 0, 1);

        // Write presented while the response path is full
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        step(1, 1, 4, 32'hC0FFEE55, 4'hF, 0);
        chk1("stall_wr_blocked", ready_o, 1'b0);
        step(1, 1, 4, 32'hC0FFEE55, 4'hF, 1);
        step(1, 1, 4, 32'hC0FFEE55, 4'hF, 0);
        step(1, 0, 4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk32("stall_wr_order", data_o, 32'hC0FFEE55);
        step(0, 0, 0, 0, 0, 1);

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, ELS-1)),
                 $urandom, MW'($urandom), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        chk1("drained_v_o", v_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
